pll_lock_reset_seq: RTL

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

---
 rtl/pll_lock_reset_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_reset_seq.sv
// PLL lock filter and sequenced reset release: waits for a stable, synchronised
// lock flag, then drops the domain resets one after another, bit 0 first.
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int N_RST          = 3,
    parameter int LOCK_FILTER    = 16,
    parameter int STAGE_DELAY    = 8,
    parameter int RELOCK_TIMEOUT = 65535,
    parameter int CNT_W          = 8
) (
    input  logic             clock_in,
    input  logic             rst_in,
    input  logic             pll_locked_in,
    input  logic             soft_rst_in,
    output logic             locked,
    output logic [N_RST-1:0] rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic             pll_relock_req
);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN,
        HOLD
    } state_t;

    localparam logic [15:0]      LOCK_TARGET  = 16'(LOCK_FILTER);
    localparam logic [15:0]      STAGE_LAST   = 16'(STAGE_DELAY - 1);
    localparam logic [15:0]      TMO_LAST     = 16'(RELOCK_TIMEOUT - 1);
    localparam logic [N_RST-1:0] FIRST_REL    = {N_RST{1'b1}} << 1;
    localparam logic             RUN_ON_ENTRY = (N_RST == 1);

    logic [1:0] rst_sync_q;
    logic       rst_n_sync;

    // NOTE: rst_in asserts asynchronously but is released through two flops, so
    // no state flop ever sees reset removal close to a clock edge.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   lock_s;

    always_ff @(posedge clock_in or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_in};
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    state_t           state_q;
    logic [15:0]      fcnt_q;
    logic [15:0]      fcnt_inc;
    logic [15:0]      scnt_q;
    logic [15:0]      tmo_q;
    logic             locked_q;
    logic [N_RST-1:0] rst_q;
    logic             ready_q;
    logic [CNT_W-1:0] loss_q;
    logic             relock_q;

    // The filter count is always zero in WAIT_LOCK, so +1 also gives the entry value.
    assign fcnt_inc = fcnt_q + 16'd1;

    // NOTE: every register here uses <= so all branches read pre-edge values.
    always_ff @(posedge clock_in or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q  <= WAIT_LOCK;
            fcnt_q   <= '0;
            scnt_q   <= '0;
            tmo_q    <= '0;
            locked_q <= 1'b0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            loss_q   <= '0;
            relock_q <= 1'b0;
        end else begin
            relock_q <= 1'b0;
            case (state_q)
                WAIT_LOCK, FILTER: begin
                    if (lock_s && fcnt_inc == LOCK_TARGET) begin
                        locked_q <= 1'b1;
                        rst_q    <= FIRST_REL;
                        scnt_q   <= '0;
                        ready_q  <= RUN_ON_ENTRY;
                        state_q  <= RUN_ON_ENTRY ? RUN : RELEASE;
                        fcnt_q   <= '0;
                        tmo_q    <= '0;
                    end else begin
                        if (lock_s) begin
                            fcnt_q  <= fcnt_inc;
                            state_q <= FILTER;
                        end else begin
                            fcnt_q  <= '0;
                            state_q <= WAIT_LOCK;
                        end
                        if (RELOCK_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                            tmo_q    <= '0;
                            relock_q <= !relock_q;
                        end else begin
                            tmo_q <= tmo_q + 16'd1;
                        end
                    end
                end
                RELEASE, RUN, HOLD: begin
                    tmo_q <= '0;
                    if (!lock_s) begin
                        rst_q    <= '1;
                        locked_q <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= WAIT_LOCK;
                        if (loss_q != {CNT_W{1'b1}}) begin
                            loss_q <= loss_q + CNT_W'(1);
                        end
                    end else if (state_q == HOLD) begin
                        if (!soft_rst_in) begin
                            rst_q   <= FIRST_REL;
                            scnt_q  <= '0;
                            ready_q <= RUN_ON_ENTRY;
                            state_q <= RUN_ON_ENTRY ? RUN : RELEASE;
                        end
                    end else if (soft_rst_in) begin
                        rst_q   <= '1;
                        ready_q <= 1'b0;
                        state_q <= HOLD;
                    end else if (state_q == RELEASE) begin
                        if (scnt_q == STAGE_LAST) begin
                            scnt_q <= '0;
                            rst_q  <= rst_q << 1;
                            if ((rst_q << 1) == '0) begin
                                ready_q <= 1'b1;
                                state_q <= RUN;
                            end
                        end else begin
                            scnt_q <= scnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign locked          = locked_q;
    assign rst_out         = rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;
    assign pll_relock_req  = relock_q;

endmodule
